i2c_init_sequencer: RTL and testbench

Boot-time configuration sequencer for the synth's audio codec. After a `start` pulse it walks a fixed table of configuration bytes and issues each one as a write transaction to `i2c_controller`. It drives the controller's `enable`/`mode`/`byte`/`periph_addr` inputs and uses a busy handshake from the controller. It sits between the top-level power-on logic and `i2c_controller`, and reports `done` or `error` to the rest of the synth.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_init_sequencer_if.sv | 28 ++
 rtl/i2c_init_rom.sv | 29 ++
 rtl/i2c_init_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module   : i2c_pkg
//  Brief    : Shared types and constants for the codec I2C init path.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } seq_state_e;

    localparam logic       I2C_MODE_WRITE         = 1'b1;
    localparam logic       I2C_MODE_READ          = 1'b0;
    localparam logic [6:0] I2C_DEFAULT_CODEC_ADDR = 7'h1A;

endpackage

`default_nettype wire

// File: rtl/i2c_init_sequencer_if.sv
// ============================================================================
//  Module   : i2c_init_sequencer_if
//  Brief    : Request/busy handshake between the init sequencer and the
//             I2C controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_init_sequencer_if;
    logic       i2c_enable;
    logic       i2c_mode;
    logic [6:0] i2c_periph_addr;
    logic [7:0] i2c_byte;
    logic       i2c_busy;
    logic       i2c_nack;

    modport master (
        output i2c_enable, i2c_mode, i2c_periph_addr, i2c_byte,
        input  i2c_busy, i2c_nack
    );

    modport slave (
        input  i2c_enable, i2c_mode, i2c_periph_addr, i2c_byte,
        output i2c_busy, i2c_nack
    );
endinterface

`default_nettype wire

// File: rtl/i2c_init_rom.sv
// ============================================================================
//  Module   : i2c_init_rom
//  Brief    : Codec configuration table, 6-bit index to 8-bit byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_init_rom (
    input  logic [5:0] i_index,
    output logic [7:0] o_byte
);

    always_comb begin
        case (i_index)
            6'd0:    o_byte = 8'h1E;
            6'd1:    o_byte = 8'h05;
            6'd2:    o_byte = 8'h97;
            6'd3:    o_byte = 8'h12;
            6'd4:    o_byte = 8'h0C;
            6'd5:    o_byte = 8'h07;
            6'd6:    o_byte = 8'h01;
            6'd7:    o_byte = 8'h42;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
// ============================================================================
//  Module   : i2c_init_sequencer
//  Brief    : Walks the codec ROM and issues each byte as an I2C write.
//             Build macro CODEC_INIT_RETRY_EN enables per-entry NACK retries.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter int         NUM_CMDS       = 8,
    parameter logic [6:0] PERIPH_ADDR    = I2C_DEFAULT_CODEC_ADDR,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    i2c_init_sequencer_if.master i2c,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [5:0]           cmd_index
);

    localparam logic [5:0]  c_last_idx     = 6'(NUM_CMDS - 1);
    localparam logic [7:0]  c_gap_last     = 8'(GAP_CYCLES - 1);
    localparam logic [10:0] c_timeout_last = 11'(TIMEOUT_CYCLES - 1);

    if (NUM_CMDS < 1 || NUM_CMDS > 64) begin : g_chk_num_cmds
        $error("NUM_CMDS out of range 1..64");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_chk_gap
        $error("GAP_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2047) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES does not fit the 11-bit timer");
    end
    if (MAX_RETRIES < 0 || MAX_RETRIES > 3) begin : g_chk_retries
        $error("MAX_RETRIES does not fit the 2-bit retry counter");
    end

    seq_state_e  state_q, state_d;
    logic        enable_q, enable_d;
    logic        mode_q, mode_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [5:0]  idx_q, idx_d;
    logic [10:0] timer_q, timer_d;
    logic [7:0]  gap_q, gap_d;
    logic        busy_prev_q, busy_prev_d;
`ifdef CODEC_INIT_RETRY_EN
    localparam logic [1:0] c_max_retries = 2'(MAX_RETRIES);
    logic [1:0]  retry_q, retry_d;
    logic        resend_q, resend_d;
`endif

    logic [7:0]  w_rom_byte;
    logic [10:0] w_timer_inc;
    logic        w_timer_expired;
    logic        w_busy_fell;

    i2c_init_rom u_rom (
        .i_index (idx_q),
        .o_byte  (w_rom_byte)
    );

    assign w_timer_inc     = (timer_q == 11'h7FF) ? timer_q : timer_q + 11'd1;
    assign w_timer_expired = (timer_q == c_timeout_last);
    // NACK is only meaningful on the cycle the controller releases busy
    assign w_busy_fell     = busy_prev_q & ~i2c.i2c_busy;

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        done_d      = done_q;
        error_d     = error_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        busy_prev_d = i2c.i2c_busy;
`ifdef CODEC_INIT_RETRY_EN
        retry_d     = retry_q;
        resend_d    = resend_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    idx_d    = 6'd0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
`ifdef CODEC_INIT_RETRY_EN
                    retry_d  = 2'd0;
                    resend_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                byte_d  = w_rom_byte;
                timer_d = 11'd0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i2c.i2c_busy) begin
                    timer_d = 11'd0;
                    state_d = ST_WAIT_DONE;
                end else if (w_timer_expired) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (w_busy_fell) begin
                    gap_d = 8'd0;
                    if (i2c.i2c_nack) begin
`ifdef CODEC_INIT_RETRY_EN
                        if (retry_q == c_max_retries) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end else begin
                            retry_d  = retry_q + 2'd1;
                            resend_d = 1'b1;
                            state_d  = ST_GAP;
                        end
`else
                        state_d = ST_ERROR;
                        error_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (w_timer_expired) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else begin
                    timer_d = w_timer_inc;
                end
            end
            ST_GAP: begin
                if (gap_q == c_gap_last) begin
`ifdef CODEC_INIT_RETRY_EN
                    // a retry reloads the same entry instead of advancing
                    state_d  = resend_q ? ST_LOAD : ST_NEXT;
                    resend_d = 1'b0;
`else
                    state_d = ST_NEXT;
`endif
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            ST_NEXT: begin
`ifdef CODEC_INIT_RETRY_EN
                retry_d = 2'd0;
`endif
                if (idx_q == c_last_idx) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d   = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
        enable_d = (state_d == ST_ISSUE);
        mode_d   = busy_d ? I2C_MODE_WRITE : I2C_MODE_READ;
        addr_d   = busy_d ? PERIPH_ADDR : 7'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            mode_q      <= 1'b0;
            addr_q      <= 7'h00;
            byte_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            idx_q       <= 6'd0;
            timer_q     <= 11'd0;
            gap_q       <= 8'd0;
            busy_prev_q <= 1'b0;
`ifdef CODEC_INIT_RETRY_EN
            retry_q     <= 2'd0;
            resend_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            busy_prev_q <= busy_prev_d;
`ifdef CODEC_INIT_RETRY_EN
            retry_q     <= retry_d;
            resend_q    <= resend_d;
`endif
        end
    end

    assign i2c.i2c_enable      = enable_q;
    assign i2c.i2c_mode        = mode_q;
    assign i2c.i2c_periph_addr = addr_q;
    assign i2c.i2c_byte        = byte_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;
    assign cmd_index           = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
// ============================================================================
//  Module   : tb_i2c_init_sequencer
//  Brief    : Self-checking bench with a behavioural I2C controller model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_init_sequencer;

    localparam int NCMD     = 4;
    localparam int GAP      = 2;
    localparam int TMO      = 1024;
    localparam int MAXR     = 3;
    localparam int BUSY_LEN = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [5:0] cmd_index;

    i2c_init_sequencer_if bus ();

    i2c_init_sequencer #(
        .NUM_CMDS       (NCMD),
        .PERIPH_ADDR    (7'h1A),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i2c       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_index (cmd_index)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] rom_exp [0:3] = '{8'h1E, 8'h05, 8'h97, 8'h12};

    // scoreboard: planned entry index and NACK response per transaction
    int exp_entry_q[$];
    bit exp_nack_q[$];
    int txn_count = 0;
    bit ctrl_mute = 1'b0;
    int ctrl_cnt  = 0;
    bit ctrl_nack = 1'b0;
    int ctrl_e    = 0;

    initial begin
        bus.i2c_busy = 1'b0;
        bus.i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_nack = 1'b0;
            if (reset) begin
                bus.i2c_busy = 1'b0;
                ctrl_cnt     = 0;
            end else if (ctrl_cnt > 0) begin
                ctrl_cnt--;
                if (ctrl_cnt == 0) begin
                    bus.i2c_busy = 1'b0;
                    bus.i2c_nack = ctrl_nack;
                end
            end else if (bus.i2c_enable && !ctrl_mute) begin
                txn_count++;
                check("txn_expected", 64'(exp_entry_q.size() != 0), 1);
                ctrl_nack = 1'b0;
                if (exp_entry_q.size() != 0) begin
                    ctrl_e    = exp_entry_q.pop_front();
                    ctrl_nack = exp_nack_q.pop_front();
                    check("txn_addr_mode_byte",
                          {bus.i2c_periph_addr, bus.i2c_mode, bus.i2c_byte},
                          {7'h1A, 1'b1, rom_exp[ctrl_e]});
                end
                bus.i2c_busy = 1'b1;
                ctrl_cnt     = BUSY_LEN;
            end
        end
    end

    int   done_rises = 0;
    logic done_prev  = 1'b0;
    initial forever begin
        @(negedge clk);
        if (done && !done_prev) done_rises++;
        done_prev = done;
    end

    typedef struct {
        int         nack_entry;
        int         nack_times;
        logic       exp_done;
        logic       exp_error;
        logic [5:0] exp_idx;
        int         exp_txns;
    } row_t;

    row_t rows [5];

    task automatic plan_push(input int e, input bit n);
        exp_entry_q.push_back(e);
        exp_nack_q.push_back(n);
    endtask

    task automatic build_plan(input int ne, input int nt);
        for (int e = 0; e < NCMD; e++) begin
            if (e != ne) begin
                plan_push(e, 1'b0);
            end else begin
`ifdef CODEC_INIT_RETRY_EN
                for (int a = 0; a <= MAXR; a++) begin
                    if (a < nt) plan_push(e, 1'b1);
                    else begin
                        plan_push(e, 1'b0);
                        break;
                    end
                end
                if (nt > MAXR) return;
`else
                if (nt > 0) begin
                    plan_push(e, 1'b1);
                    return;
                end
                plan_push(e, 1'b0);
`endif
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int cyc;
        cyc = 0;
        while (!(done || error) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finished"}, 64'(done || error), 1);
    endtask

    task automatic run_row(input int r);
        int base;
        build_plan(rows[r].nack_entry, rows[r].nack_times);
        base = txn_count;
        pulse_start();
        wait_finish($sformatf("row%0d", r));
        @(negedge clk);
        check($sformatf("row%0d_status", r), {done, error, busy}, {rows[r].exp_done, rows[r].exp_error, 1'b0});
        check($sformatf("row%0d_cmd_index", r), cmd_index, rows[r].exp_idx);
        check($sformatf("row%0d_bus_idle", r), {bus.i2c_periph_addr, bus.i2c_enable, bus.i2c_mode}, 0);
        check($sformatf("row%0d_txns", r), 64'(txn_count - base), 64'(rows[r].exp_txns));
        check($sformatf("row%0d_sb_empty", r), 64'(exp_entry_q.size()), 0);
    endtask

    initial begin
        int cyc;
        int en_seen;
        int base;

        rows[0] = '{-1, 0, 1'b1, 1'b0, 6'd3, 4};
`ifdef CODEC_INIT_RETRY_EN
        rows[1] = '{2, 1, 1'b1, 1'b0, 6'd3, 5};
        rows[2] = '{2, 4, 1'b0, 1'b1, 6'd2, 6};
        rows[3] = '{0, 2, 1'b1, 1'b0, 6'd3, 6};
        rows[4] = '{3, 3, 1'b1, 1'b0, 6'd3, 7};
`else
        rows[1] = '{2, 1, 1'b0, 1'b1, 6'd2, 3};
        rows[2] = '{2, 4, 1'b0, 1'b1, 6'd2, 3};
        rows[3] = '{0, 2, 1'b0, 1'b1, 6'd0, 1};
        rows[4] = '{3, 3, 1'b0, 1'b1, 6'd3, 4};
`endif

        // reset and idle
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {bus.i2c_enable, bus.i2c_mode, bus.i2c_periph_addr, bus.i2c_byte, busy, done, error, cmd_index}, 0);
        en_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.i2c_enable) en_seen++;
        end
        check("idle_no_enable", 64'(en_seen), 0);

        // start latency and issue timeout with a silent controller
        ctrl_mute = 1'b1;
        pulse_start();
        check("latency_load", bus.i2c_enable, 0);
        @(negedge clk);
        check("latency_issue", {bus.i2c_enable, bus.i2c_mode, bus.i2c_periph_addr, busy}, {1'b1, 1'b1, 7'h1A, 1'b1});
        cyc = 0;
        while (!error && cyc < 1100) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", 64'(cyc), 64'(TMO));
        check("timeout_state", {error, done, busy, bus.i2c_enable, cmd_index}, {1'b1, 1'b0, 1'b0, 1'b0, 6'd0});
        ctrl_mute = 1'b0;

        for (int r = 0; r < 5; r++) run_row(r);

        // start pulse while busy is dropped
        done_rises = 0;
        build_plan(-1, 0);
        base = txn_count;
        pulse_start();
        cyc = 0;
        while (txn_count - base < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("swb_reached_entry1", 64'(txn_count - base >= 2), 1);
        pulse_start();
        wait_finish("swb");
        @(negedge clk);
        check("swb_txns", 64'(txn_count - base), 4);
        check("swb_done_once", 64'(done_rises), 1);
        check("swb_done", {done, error, busy}, {1'b1, 1'b0, 1'b0});

        // reset during WAIT_DONE of entry 1
        build_plan(-1, 0);
        base = txn_count;
        pulse_start();
        cyc = 0;
        while (txn_count - base < 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("rstmid_in_entry1", {busy, cmd_index}, {1'b1, 6'd1});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_outputs", {bus.i2c_enable, busy, cmd_index, done, error}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_entry_q.delete();
        exp_nack_q.delete();
        run_row(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
